// File: rtl/echo_app_flow_sched_pkg.sv
// Shared constants for the echo application's flow scheduler.
// Flow ID width and flow count are the codebase-wide values; the
// occupancy width is derived from the flow count.
package echo_app_flow_sched_pkg;

  localparam int SCHED_FLOW_ID_W    = 3;
  localparam int SCHED_MAX_FLOW_CNT = 8;
  localparam int FLOW_SCHED_OCC_W   = $clog2(SCHED_MAX_FLOW_CNT) + 1;

  // Advance a circular-buffer pointer, wrapping modulo depth.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/echo_flow_sched_ring.sv
// Circular flow-ID storage: head/tail pointers, occupancy counter,
// push/pop with full/empty. Pushes while full and pops while empty are ignored.
// Storage contents are data only and are not reset.
module echo_flow_sched_ring
  import echo_app_flow_sched_pkg::*;
#(
  parameter  int W     = SCHED_FLOW_ID_W,
  parameter  int DEPTH = SCHED_MAX_FLOW_CNT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (occupancy == '0);
  assign full      = (occupancy == OCC_W'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[head_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) tail_ptr <= PTR_W'(wrap_inc(int'(tail_ptr), DEPTH));
      if (do_pop)  head_ptr <= PTR_W'(wrap_inc(int'(head_ptr), DEPTH));
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Entry write at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/echo_app_flow_sched.sv
// Round-robin flow scheduler for the echo copy engine.
// Merges registered new-flow notifications (priority) with controller
// requeues, tracks open flows and drops dead queue heads internally.
// Optional macro FLOW_SCHED_DEDUP_EN: keep a queued bitmap so a flow is
// stored at most once; duplicate enqueues complete but write nothing.
module echo_app_flow_sched
  import echo_app_flow_sched_pkg::*;
#(
  parameter  int FLOW_ID_W = SCHED_FLOW_ID_W,
  parameter  int MAX_FLOWS = SCHED_MAX_FLOW_CNT,
  localparam int OCC_W     = $clog2(MAX_FLOWS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_flow_val,
  input  logic [FLOW_ID_W-1:0] new_flow_flowid,
  input  logic                 close_flow_val,
  input  logic [FLOW_ID_W-1:0] close_flow_flowid,
  input  logic                 requeue_val,
  input  logic [FLOW_ID_W-1:0] requeue_flowid,
  output logic                 requeue_rdy,
  output logic                 sched_val,
  output logic [FLOW_ID_W-1:0] sched_flowid,
  input  logic                 sched_yumi,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 err_overflow
);

  logic                 notif_q;
  logic [FLOW_ID_W-1:0] notif_id_q;
  logic [MAX_FLOWS-1:0] active;
  logic [FLOW_ID_W-1:0] head_id;
  logic                 full;
  logic                 empty;
  logic                 enq_req;
  logic [FLOW_ID_W-1:0] enq_id;
  logic                 enq_write;
  logic                 push;
  logic                 pop;
  logic                 skip;
  logic                 head_live;

  echo_flow_sched_ring #(
    .W     (FLOW_ID_W),
    .DEPTH (MAX_FLOWS)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enq_id),
    .pop       (pop),
    .head_data (head_id),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

`ifdef FLOW_SCHED_DEDUP_EN
  logic [MAX_FLOWS-1:0] queued;
`endif

  // Enqueue arbitration, dead-head skip and handshake outputs.
  always_comb begin
    head_live    = ~empty & active[head_id];
    sched_val    = ~rst & head_live;
    sched_flowid = sched_val ? head_id : '0;
    skip         = ~rst & ~empty & ~active[head_id];
    pop          = skip | (sched_val & sched_yumi);
    requeue_rdy  = ~rst & ~notif_q & ~full;
    enq_req      = notif_q | (requeue_val & requeue_rdy);
    enq_id       = notif_q ? notif_id_q : requeue_flowid;
`ifdef FLOW_SCHED_DEDUP_EN
    enq_write    = enq_req & ~queued[enq_id];
`else
    enq_write    = enq_req;
`endif
    push         = enq_write & ~full;
  end

  // Notification staging register; the ID is data and is not reset.
  always_ff @(posedge clk) begin
    if (rst) notif_q <= 1'b0;
    else     notif_q <= new_flow_val;
    notif_id_q <= new_flow_flowid;
  end

  // Open-flow bitmap: close clears, notification sets, set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else begin
      logic [MAX_FLOWS-1:0] nxt;
      nxt = active;
      if (close_flow_val) nxt[close_flow_flowid] = 1'b0;
      if (notif_q)        nxt[notif_id_q]        = 1'b1;
      active <= nxt;
    end
  end

`ifdef FLOW_SCHED_DEDUP_EN
  // Queued bitmap: pop clears, write sets, set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      queued <= '0;
    end else begin
      logic [MAX_FLOWS-1:0] nxt;
      nxt = queued;
      if (pop)  nxt[head_id] = 1'b0;
      if (push) nxt[enq_id]  = 1'b1;
      queued <= nxt;
    end
  end
`endif

  // Sticky overflow flag for writes dropped at full.
  always_ff @(posedge clk) begin
    if (rst)                    err_overflow <= 1'b0;
    else if (enq_write && full) err_overflow <= 1'b1;
  end

endmodule

// File: doc/echo_app_flow_sched.md
# echo_app_flow_sched

Round-robin flow scheduler for the echo application's copy engine. It owns the queue of flow IDs that the copy controller services. It merges new-flow notifications from the TCP engine with requeue requests from the copy controller, and presents one flow at a time on a valid/yumi interface. It also tracks which flows are open and silently discards queued entries of closed flows, so the controller never sees a dead flow.

## Interface
Parameters:
- FLOW_ID_W, default `FLOW_ID_W: flow ID width.
- MAX_FLOWS, default `MAX_FLOW_CNT: number of flows; also the queue depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- new_flow_val  in  1  new-flow notification; no ready, always accepted
- new_flow_flowid  in  FLOW_ID_W  ID of the new flow
- close_flow_val  in  1  flow closed
- close_flow_flowid  in  FLOW_ID_W  ID of the closed flow
- requeue_val  in  1  controller returns a flow to the queue
- requeue_flowid  in  FLOW_ID_W  ID of the returned flow
- requeue_rdy  out  1  requeue accepted when val & rdy
- sched_val  out  1  head flow available
- sched_flowid  out  FLOW_ID_W  head flow ID
- sched_yumi  in  1  consumer takes the head; legal only when sched_val=1
- occupancy  out  $clog2(MAX_FLOWS)+1  number of stored entries, including dead entries
- err_overflow  out  1  sticky; set when a write is dropped because the queue is full

## Operation
- Storage is a circular buffer of MAX_FLOWS entries with head and tail pointers of $clog2(MAX_FLOWS) bits. Pointers wrap modulo MAX_FLOWS.
- empty = (occupancy == 0); full = (occupancy == MAX_FLOWS).
- Notification register: new_flow_val and new_flow_flowid are registered for one cycle (notif_q, notif_id_q) before enqueue.
- Enqueue priority: notif_q always wins. When notif_q=1, the requeue port is blocked.
- requeue_rdy = ~notif_q & ~full.
- active[MAX_FLOWS] bitmap:
  - bit set when notif_q enqueues a flow;
  - bit cleared on close_flow_val;
  - if a set and a clear hit the same flow in the same cycle, set wins.
- Head handling:
  - sched_val = ~empty & active[head flow].
  - If the queue is not empty and the head flow is inactive, the head entry is popped internally in that cycle. The skip takes 1 cycle per dead entry and nothing is presented on sched_val.
- sched_yumi pops the head. A close of the same flow in the same cycle does not cancel the yumi; the flow is handed out.
- If an enqueue finds the queue full, the write is dropped and err_overflow is set. err_overflow clears only on rst.
- occupancy changes by +1 per enqueue and -1 per pop (yumi or skip). A simultaneous enqueue and pop leaves it unchanged.

## Timing
- Reset values:
  - sched_val=0, requeue_rdy=0 during rst;
  - occupancy=0, err_overflow=0, sched_flowid=0;
  - head and tail pointers 0;
  - all bitmaps clear, notif_q=0.
- Reset mid-operation discards all queued flows and all active state.
- Latency:
  - new_flow_val at cycle T produces sched_val at T+2 if the queue was empty.
  - An accepted requeue at T produces sched_val at T+1 if the queue was empty.
- sched_val and sched_flowid are combinational from the head entry and the active bitmap only. They do not depend on sched_yumi.
- There is no bypass: an enqueue into an empty queue is never visible in the same cycle.
- When full, requeue_rdy stays 0 even if sched_yumi=1 in the same cycle.

## Configuration
- FLOW_SCHED_DEDUP_EN defined:
  - A queued[MAX_FLOWS] bitmap is kept: set on enqueue, cleared on pop (yumi or skip).
  - An enqueue of a flow already queued is accepted (handshake completes) but nothing is written.
  - Set wins over clear for the same flow in the same cycle.
  - Occupancy can never exceed the number of distinct flows, so err_overflow stays 0 in normal use.
- FLOW_SCHED_DEDUP_EN undefined:
  - No queued bitmap; duplicate entries are stored.
  - Overflow behaves as described in Operation.

## Structure
- FLOW_ID_W and MAX_FLOW_CNT come from the shared state_defs.vh; no new constants are added.
- The shared header also gains FLOW_SCHED_OCC_W = $clog2(MAX_FLOW_CNT)+1.
- One sub-module, echo_flow_sched_ring: circular storage with head/tail pointers, occupancy counter, push, pop, full and empty.
- Arbitration, the active/queued bitmaps and the skip logic live in the top module.

## Test plan
Values assume MAX_FLOWS=8.
1. Reset, then new_flow_val with ID 3 at cycle 0 -> sched_val=1 and sched_flowid=3 at cycle 2; occupancy=1.
2. New flows 1, 2, 5 on consecutive cycles, yumi each as presented -> order 1, 2, 5. Requeue 1 -> 1 is presented next cycle.
3. new_flow ID 4 at cycle 0 and requeue_val ID 6 held from cycle 1 -> requeue_rdy=0 at cycle 1 and accepted at cycle 2; 4 is dequeued before 6.
4. Flow 2 queued, requeue 2 twice:
   - with FLOW_SCHED_DEDUP_EN -> occupancy stays 1;
   - without it -> occupancy 3 and 2 is presented three times.
5. Queue holds 1, 2; close 1 -> one skip cycle with sched_val=0, then 2 is presented; occupancy goes 2 -> 1.
6. Fill with 8 flows -> requeue_rdy=0, and stays 0 with yumi and requeue in the same cycle. Without the macro, a ninth new_flow -> err_overflow=1 until rst, occupancy=8.
